// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI master
// Purpose: FSM state encoding and chip-select decode used by spi_master_gen2.
// Contents:
//   spi_state_t    IDLE, LEAD, XFER, TRAIL
//   SPI_MAX_CS     widest chip-select vector the decoder produces
//   spi_cs_decode  one-hot select mask; all zero when sel >= n
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  localparam int SPI_MAX_CS = 8;

  // An out-of-range index yields an empty mask, so no slave is selected.
  function automatic logic [SPI_MAX_CS-1:0] spi_cs_decode(input logic [2:0] sel, input int n);
    logic [SPI_MAX_CS-1:0] mask;
    mask = '0;
    if (int'(sel) < n) mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK divider and toggle for the SPI master
// Purpose: divides sys_clk into SCK half-periods and reports each SCK edge.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   en         in   divider runs while high, held at zero otherwise
//   run        in   SCK toggles on each divider tick while high
//   load       in   loads the idle level (captured cpol) onto SCK
//   load_level in   idle level to load
//   sck        out  registered serial clock
//   tick       out  last cycle of a CLK_DIV-cycle period
//   lead_edge  out  SCK leaves its idle level on the next edge
//   trail_edge out  SCK returns to its idle level on the next edge
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic run,
  input  logic load,
  input  logic load_level,
  output logic sck,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             idle_level;
  logic             toggle;

  assign tick       = en && (div_cnt == DIV_LAST);
  assign toggle     = tick && run;
  // Strobes are combinational so the FSM acts on the same edge SCK moves.
  assign lead_edge  = toggle && (sck == idle_level);
  assign trail_edge = toggle && (sck != idle_level);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      sck        <= 1'b0;
      idle_level <= 1'b0;
    end else begin
      if (!en || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + DIV_W'(1);

      if (load) begin
        sck        <= load_level;
        idle_level <= load_level;
      end else if (toggle) begin
        sck <= ~sck;
      end
    end
  end

endmodule

// File: rtl/spi_master_gen2.sv
// rtl/spi_master_gen2.sv - parametrised SPI master, one word per start pulse
// Purpose: runtime CPOL/CPHA, divided SCK, one-hot active-low chip selects,
//   start/busy/done handshake. Optional macro SPI_MASTER_LOOPBACK_EN adds a
//   loopback input that feeds the sampler from MOSI instead of MISO.
// Ports:
//   sys_clk   in   sole clock
//   rst       in   synchronous active-high reset
//   start     in   transfer request, accepted in IDLE
//   data_in   in   TX word, captured on accepted start
//   cs_sel    in   slave index, captured on accepted start
//   cpol      in   SCK idle level, captured on accepted start
//   cpha      in   0: sample leading edge, 1: sample trailing edge
//   busy      out  high while a transfer is in flight
//   done      out  one-cycle end-of-transfer pulse
//   data_out  out  RX word, updated with done
//   SCK       out  serial clock
//   MOSI      out  serial data out
//   MISO      in   serial data in
//   loopback  in   (SPI_MASTER_LOOPBACK_EN only) sample MOSI instead of MISO
//   cs_n      out  active-low chip selects
module spi_master_gen2
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int CLK_DIV     = 2,
  parameter int NUM_CS      = 1,
  parameter int MSB_FIRST   = 0
) (
  input  logic                                          sys_clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [DATA_LENGTH-1:0]                        data_in,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
  input  logic                                          cpol,
  input  logic                                          cpha,
  output logic                                          busy,
  output logic                                          done,
  output logic [DATA_LENGTH-1:0]                        data_out,
  output logic                                          SCK,
  output logic                                          MOSI,
  input  logic                                          MISO,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                                          loopback,
`endif
  output logic [NUM_CS-1:0]                             cs_n
);

  localparam int CNT_W = $clog2(2 * DATA_LENGTH) + 1;
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_LENGTH - 1);

  spi_state_t             state;
  logic [DATA_LENGTH-1:0] tx_sh;
  logic [DATA_LENGTH-1:0] rx_sh;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   cpha_q;
  logic                   tick;
  logic                   lead_edge;
  logic                   trail_edge;
  logic                   sck_edge;
  logic                   sample_edge;
  logic                   drive_edge;
  logic                   rx_bit;
  logic                   accept;
  logic [NUM_CS-1:0]      cs_start_n;

  function automatic logic head(input logic [DATA_LENGTH-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_LENGTH-1] : w[0];
  endfunction

  function automatic logic [DATA_LENGTH-1:0] advance(input logic [DATA_LENGTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_LENGTH-2:0], 1'b0} : {1'b0, w[DATA_LENGTH-1:1]};
  endfunction

  // Received bits enter from the end opposite to the one transmitted first,
  // so after DATA_LENGTH samples the word sits in natural bit order.
  function automatic logic [DATA_LENGTH-1:0] shift_in(input logic [DATA_LENGTH-1:0] w,
                                                       input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_LENGTH-2:0], b} : {b, w[DATA_LENGTH-1:1]};
  endfunction

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback ? MOSI : MISO;
`else
  assign rx_bit = MISO;
`endif

  assign accept      = (state == IDLE) && start;
  assign sck_edge    = lead_edge | trail_edge;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign drive_edge  = cpha_q ? lead_edge : trail_edge;
  assign cs_start_n  = NUM_CS'(~spi_cs_decode(3'(cs_sel), NUM_CS));

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk       (sys_clk),
    .rst       (rst),
    .en        (state != IDLE),
    .run       (state == XFER),
    .load      (accept),
    .load_level(cpol),
    .sck       (SCK),
    .tick      (tick),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      MOSI     <= 1'b0;
      cs_n     <= '1;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      cpha_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LEAD;
            busy     <= 1'b1;
            cpha_q   <= cpha;
            // First bit goes out now; with cpha=0 it is already consumed,
            // with cpha=1 the first leading edge drives it again.
            MOSI     <= head(data_in);
            tx_sh    <= cpha ? data_in : advance(data_in);
            rx_sh    <= '0;
            edge_cnt <= '0;
            cs_n     <= cs_start_n;
          end
        end
        LEAD: begin
          if (tick) state <= XFER;
        end
        XFER: begin
          if (drive_edge) begin
            MOSI  <= head(tx_sh);
            tx_sh <= advance(tx_sh);
          end
          if (sample_edge) rx_sh <= shift_in(rx_sh, rx_bit);
          if (sck_edge) begin
            if (edge_cnt == LAST_EDGE) state <= TRAIL;
            edge_cnt <= edge_cnt + CNT_W'(1);
          end
        end
        TRAIL: begin
          if (tick) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            data_out <= rx_sh;
            cs_n     <= '1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen2.sv
// tb/tb_spi_master_gen2.sv - scoreboard bench for spi_master_gen2
module tb_spi_master_gen2;

  localparam int NCS = 5;
  localparam int LAT = 37;

  logic           sys_clk = 1'b0;
  logic           rst     = 1'b1;
  logic           start   = 1'b0;
  logic [7:0]     data_in = 8'h00;
  logic [2:0]     cs_sel  = 3'd0;
  logic           cpol    = 1'b0;
  logic           cpha    = 1'b0;
  logic           busy;
  logic           done;
  logic [7:0]     data_out;
  logic           SCK;
  logic           MOSI;
  logic           MISO;
  logic [NCS-1:0] cs_n;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic           loopback = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // MISO source: 0 slave model, 1 wired to MOSI, 2 held low
  int   miso_mode  = 1;
  logic slave_miso = 1'b0;
  assign MISO = (miso_mode == 1) ? MOSI : ((miso_mode == 0) ? slave_miso : 1'b0);

  spi_master_gen2 #(
    .DATA_LENGTH(8),
    .CLK_DIV    (2),
    .NUM_CS     (NCS),
    .MSB_FIRST  (0)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .cs_sel  (cs_sel),
    .cpol    (cpol),
    .cpha    (cpha),
    .busy    (busy),
    .done    (done),
    .data_out(data_out),
    .SCK     (SCK),
    .MOSI    (MOSI),
    .MISO    (MISO),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cs_n    (cs_n)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard
  logic [7:0] exp_data_q[$];
  int         exp_cyc_q[$];
  int         n_done = 0;
  int         n_push = 0;

  always @(negedge sys_clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done seen at cycle %0d, expected no done", cyc);
      end else begin
        check("data_out", 32'(data_out), 32'(exp_data_q.pop_front()));
        check("done_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // Slave model, LSB first, mode from m_cpol/m_cpha
  logic       m_cpol = 1'b0;
  logic       m_cpha = 1'b0;
  logic [7:0] s_resp = 8'h00;
  logic [7:0] s_tx   = 8'h00;
  int         s_idx  = 0;
  logic       s_cs_prev  = 1'b0;
  logic       s_sck_prev = 1'b0;

  always @(negedge sys_clk) begin
    logic cs_act;
    logic edge_seen;
    logic lead;
    cs_act    = (cs_n != {NCS{1'b1}});
    edge_seen = (SCK != s_sck_prev);
    lead      = edge_seen && (s_sck_prev == m_cpol);
    if (rst) begin
      s_idx = 0;
    end else if (cs_act && !s_cs_prev) begin
      s_idx = 0;
      if (!m_cpha) slave_miso = s_resp[0];
    end else if (cs_act && edge_seen) begin
      if (lead == !m_cpha) begin
        if (s_idx < 8) begin
          check("mosi_at_sample", 32'(MOSI), 32'(s_tx[s_idx]));
          s_idx++;
        end
      end else if (s_idx < 8) begin
        slave_miso = s_resp[s_idx];
      end
    end
    s_cs_prev  = cs_act;
    s_sck_prev = SCK;
  end

  task automatic issue(input logic [7:0] tx, input logic pol, input logic pha,
                       input logic [2:0] sel, input int mm, input logic [7:0] resp,
                       input logic [7:0] exp_rx, input bit expect_done);
    data_in = tx; cpol = pol; cpha = pha; cs_sel = sel; miso_mode = mm;
    s_resp = resp; s_tx = tx; m_cpol = pol; m_cpha = pha;
    start = 1'b1;
    if (expect_done) begin
      exp_data_q.push_back(exp_rx);
      exp_cyc_q.push_back(cyc + LAT);
      n_push++;
    end
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic pol, input logic pha,
                          input logic [2:0] sel, input int mm, input logic [7:0] resp,
                          input logic [7:0] exp_rx);
    logic [NCS-1:0] exp_cs;
    int   rises;
    int   n;
    logic prev;
    bit   cs_ok;
    exp_cs = {NCS{1'b1}};
    if (int'(sel) < NCS) exp_cs[sel] = 1'b0;
    @(negedge sys_clk);
    issue(tx, pol, pha, sel, mm, resp, exp_rx, 1'b1);
    @(negedge sys_clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("sck_idle_lead", 32'(SCK), 32'(pol));
    rises = 0; n = 0; prev = SCK; cs_ok = 1'b1;
    while (!done && n < 200) begin
      if (cs_n != exp_cs) cs_ok = 1'b0;
      @(negedge sys_clk);
      n++;
      if (SCK && !prev) rises++;
      prev = SCK;
    end
    check("xfer_done_seen", 32'(done), 32'd1);
    check("cs_n_during", 32'(cs_ok), 32'd1);
    check("sck_rises", rises, 8);
    check("sck_idle_end", 32'(SCK), 32'(pol));
    check("cs_n_end", 32'(cs_n), 32'(5'b11111));
    check("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int   n;
    int   edges;
    int   done_before;
    logic prev;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_sck", 32'(SCK), 32'd0);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'(5'b11111));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;

    // Mode 0, MISO wired to MOSI
    run_xfer(8'hA5, 1'b0, 1'b0, 3'd0, 1, 8'h00, 8'hA5);

    // All four modes against the slave model
    for (int m = 0; m < 4; m++) begin
      run_xfer(8'hC3, m[1], m[0], 3'd0, 0, 8'h3C, 8'h3C);
    end

    // Chip-select decode, in range and out of range
    run_xfer(8'h96, 1'b0, 1'b0, 3'd2, 1, 8'h00, 8'h96);
    run_xfer(8'h0F, 1'b1, 1'b1, 3'd5, 1, 8'h00, 8'h0F);

    // Start held three cycles, then a start in the done cycle
    @(negedge sys_clk);
    issue(8'h6B, 1'b0, 1'b1, 3'd1, 1, 8'h00, 8'h6B, 1'b1);
    repeat (3) @(negedge sys_clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_cs_gap", 32'(cs_n), 32'(5'b11111));
    issue(8'h81, 1'b0, 1'b1, 3'd1, 1, 8'h00, 8'h81, 1'b1);
    @(negedge sys_clk);
    start = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    check("b2b_second_cs", 32'(cs_n), 32'(5'b11101));
    n = 0;
    while (!done && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("b2b_second_done", 32'(done), 32'd1);
    repeat (5) @(negedge sys_clk);

    // Reset at the 5th SCK edge of a cpol=1 transfer
    @(negedge sys_clk);
    issue(8'hF0, 1'b1, 1'b0, 3'd0, 1, 8'h00, 8'h00, 1'b0);
    @(negedge sys_clk);
    start = 1'b0;
    edges = 0; n = 0; prev = SCK;
    while (edges < 5 && n < 100) begin
      @(negedge sys_clk);
      n++;
      if (SCK != prev) edges++;
      prev = SCK;
    end
    check("abort_edges_reached", edges, 5);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge sys_clk);
    check("abort_cs_n", 32'(cs_n), 32'(5'b11111));
    check("abort_sck", 32'(SCK), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    done_before = n_done;
    repeat (60) @(negedge sys_clk);
    check("abort_no_done", n_done, done_before);

`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b1;
    run_xfer(8'h5A, 1'b0, 1'b0, 3'd0, 2, 8'h00, 8'h5A);
    loopback = 1'b0;
`endif

    repeat (5) @(negedge sys_clk);
    check("scoreboard_empty", exp_data_q.size(), 0);
    check("done_count", n_done, n_push);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
